// File: rtl/uart_rx_parity.sv
// uart_rx_parity -- UART serial receiver with parity check.
//
// Receives frames of 1 start bit, DBIT data bits (LSB first), 1 parity bit
// and 1 stop bit, timed by a 16x oversampling tick. Each frame, including an
// errored one, produces one rx_done_tick; dout and the status flags hold
// until the next strobe.
//
// Parameters:
//   DBIT        data bits per frame (5..8)
//   SB_TICK     s_tick periods in the stop bit (1..16)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   rx            serial line, idle high, asynchronous to clk
//   s_tick        one-clk pulse at 16x the baud rate
//   rx_done_tick  one-cycle strobe: frame complete, dout valid
//   dout          received data word
//   parity_err    parity mismatch on the last completed frame
//   frame_err     stop bit sampled low on the last completed frame
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample point uses a 2-of-3 vote
//                        of rx_s over the decision tick and the two ticks
//                        before it; decision timing is unchanged.

module uart_rx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    state_t          state;
    state_t          state_next;
    logic            rx_meta;
    logic            rx_s;
    logic            line_high;
    logic [3:0]      tick_cnt;
    logic [2:0]      bit_cnt;
    logic [DBIT-1:0] shreg;
    logic            par_acc;
    logic            par_bad;
    logic            smp;
    logic            bit_end;
    logic            stop_smp;

    // Two-flop synchronizer, reset to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // History of rx_s on the two previous ticks; the vote combines them with
    // the current rx_s so it resolves on the decision tick itself.
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '1;
        end else if (s_tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    always_comb begin
        smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    end
`else
    always_comb begin
        smp = rx_s;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (!rx_s && line_high) state_next = START;
            START:  if (s_tick && tick_cnt == 4'd7) state_next = smp ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == BIT_LAST) state_next = PARITY;
            PARITY: if (bit_end) state_next = STOP;
            STOP:   if (stop_smp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sample-point decode.
    always_comb begin
        bit_end  = s_tick && (tick_cnt == 4'd15);
        stop_smp = (state == STOP) && s_tick && (tick_cnt == STOP_LAST);
    end

    // Tick counter clears on every state entry and counts only in active
    // states; in DATA it wraps 15 -> 0 between bits without a state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (state_next != state) begin
            tick_cnt <= '0;
        end else if (s_tick && state != IDLE) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    // Data path: shift register, bit counter, running parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                START: begin
                    bit_cnt <= '0;
                    par_acc <= 1'b0;
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {smp, shreg[DBIT-1:1]};
                        par_acc <= par_acc ^ smp;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bad <= ((par_acc ^ smp) != PARITY_ODD);
                    end
                end
                default: ;
            endcase
        end
    end

    // Line-high flag: a frame ending in a framing error disarms start
    // detection until the line has been seen high on a tick again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_high <= 1'b1;
        end else if (stop_smp && !smp) begin
            line_high <= 1'b0;
        end else if (s_tick && rx_s) begin
            line_high <= 1'b1;
        end
    end

    // Registered outputs, updated together with the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= stop_smp;
            if (stop_smp) begin
                dout       <= shreg;
                parity_err <= par_bad;
                frame_err  <= !smp;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_parity.sv
// tb_uart_rx_parity -- self-checking bench for uart_rx_parity.
// Drives an even-parity and an odd-parity instance from the same line and
// scores every rx_done_tick against per-instance expectation queues.

module tb_uart_rx_parity;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic       done_e, done_o;
    logic [7:0] dout_e, dout_o;
    logic       pe_e, pe_o, fe_e, fe_o;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    exp_t xe, xo;
    int   total = 0;
    int   bad   = 0;

    uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .rx_done_tick(done_e), .dout(dout_e), .parity_err(pe_e), .frame_err(fe_e)
    );

    uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .rx_done_tick(done_o), .dout(dout_o), .parity_err(pe_o), .frame_err(fe_o)
    );

    always #5 clk = ~clk;

    // s_tick: one clk wide, every 4 clk.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Return on the falling edge following the next s_tick.
    task automatic tick_wait();
        do @(posedge clk); while (s_tick !== 1'b1);
        @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n) tick_wait();
    endtask

    // Send one frame; spike forces rx high for that tick index, abort_at
    // asserts reset at that tick index and leaves the frame unfinished.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int spike, input int abort_at);
        logic [10:0] bits;
        int          idx;
        exp_t        ee, eo;
        bits = {stp, par, d, 1'b0};
        if (abort_at == 0) begin
            ee.d  = d;  ee.pe = ((^d) ^ par) != 1'b0; ee.fe = ~stp;
            eo.d  = d;  eo.pe = ((^d) ^ par) != 1'b1; eo.fe = ~stp;
            q_e.push_back(ee);
            q_o.push_back(eo);
        end
        for (int t = 1; t <= 16 * 11; t++) begin
            if (t == abort_at) begin
                rx    = 1'b1;
                reset = 1'b0;
                return;
            end
            idx = (t - 1) / 16;
            rx  = bits[idx] | (t == spike);
            tick_wait();
        end
    endtask

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (done_e === 1'b1) begin
            check("even_strobe_expected", 32'(q_e.size() != 0), 1);
            if (q_e.size() != 0) begin
                xe = q_e.pop_front();
                check("even_dout", dout_e, xe.d);
                check("even_parity_err", pe_e, xe.pe);
                check("even_frame_err", fe_e, xe.fe);
            end
        end
        if (done_o === 1'b1) begin
            check("odd_strobe_expected", 32'(q_o.size() != 0), 1);
            if (q_o.size() != 0) begin
                xo = q_o.pop_front();
                check("odd_dout", dout_o, xo.d);
                check("odd_parity_err", pe_o, xo.pe);
                check("odd_frame_err", fe_o, xo.fe);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done_e"}, done_e, 0);
        check({tag, "_dout_e"}, dout_e, 0);
        check({tag, "_pe_e"}, pe_e, 0);
        check({tag, "_fe_e"}, fe_e, 0);
        check({tag, "_done_o"}, done_o, 0);
        check({tag, "_dout_o"}, dout_o, 0);
        check({tag, "_pe_o"}, pe_o, 0);
        check({tag, "_fe_o"}, fe_o, 0);
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        idle_ticks(20);

        // Parity cases, scored for both builds.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
        send_frame(8'h00, 1'b1, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 0, 0);
        idle_ticks(10);

        // Short low glitch: false start, outputs hold.
        rx = 1'b0;
        repeat (4) tick_wait();
        idle_ticks(30);
        check("glitch_dout_e", dout_e, 8'hFF);
        check("glitch_pe_e", pe_e, 0);
        check("glitch_pe_o", pe_o, 1);
        check("glitch_fe_e", fe_e, 0);

`ifdef UART_RX_MAJORITY_EN
        // One-tick spike at the mid-point of data bit 3 is voted out.
        send_frame(8'h00, 1'b0, 1'b1, 72, 0);
        idle_ticks(10);
`endif

        // Framing error followed by a held-low line (break).
        send_frame(8'h55, 1'b0, 1'b0, 0, 0);
        rx = 1'b0;
        repeat (3 * 176) tick_wait();
        check("break_fe_held", fe_e, 1);
        check("break_queue_drained", q_e.size(), 0);
        idle_ticks(20);
        send_frame(8'h81, 1'b0, 1'b1, 0, 0);
        idle_ticks(10);
        check("after_break_fe", fe_e, 0);

        // Reset in the middle of data bit 4.
        send_frame(8'hC3, 1'b1, 1'b1, 0, 88);
        #1;
        check_reset_outputs("midreset");
        repeat (6) @(negedge clk);
        reset = 1'b1;
        idle_ticks(20);
        send_frame(8'h12, 1'b0, 1'b1, 0, 0);
        idle_ticks(20);

        check("final_queue_even", q_e.size(), 0);
        check("final_queue_odd", q_o.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
